knn_vote: RTL and testbench

//  Downstream stage of the KNN sorter. After the sorter asserts DONE, this block

---
 rtl/knn_vote_if.sv | 27 ++
 rtl/knn_vote.sv | 116 +++++++++++
 tb/tb_knn_vote.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/knn_vote_if.sv
// Handshake between the KNN sorter side (master) and the majority-vote stage (slave).
// Carries start/nvalid, the rank-select read port and the vote result.
interface knn_vote_if #(
   parameter int LABEL_W = 8,
   parameter int SEL_W   = 2,
   parameter int CNT_W   = 3
);
   logic               start;
   logic [CNT_W-1:0]   nvalid;
   logic [SEL_W-1:0]   sel;
   logic [LABEL_W-1:0] label_in;
   logic               busy;
   logic               result_valid;
   logic [LABEL_W-1:0] result_label;
   logic [CNT_W-1:0]   result_count;
   logic               result_empty;

   modport master (
      output start, nvalid, label_in,
      input  sel, busy, result_valid, result_label, result_count, result_empty
   );

   modport slave (
      input  start, nvalid, label_in,
      output sel, busy, result_valid, result_label, result_count, result_empty
   );
endinterface

// File: rtl/knn_vote.sv
// Majority vote over the K nearest-neighbour labels read from the sorter.
// Fetches all K ranks, then evaluates one rank per cycle; ties go to the nearest rank.
module knn_vote #(
   parameter int K       = 4,
   parameter int LABEL_W = 8,
   parameter int SEL_W   = 2,
   parameter int CNT_W   = 3
) (
   input logic        clk,
   input logic        rst,
   knn_vote_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VOTE} state_t;

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(K - 1);

   state_t             r_state;
   logic [SEL_W-1:0]   r_idx;
   logic [SEL_W-1:0]   r_sel;
   logic [CNT_W-1:0]   r_nv;
   logic [LABEL_W-1:0] r_lab [K];
   logic [CNT_W-1:0]   r_best_cnt;
   logic [LABEL_W-1:0] r_best_lab;
   logic               r_busy;
   logic               r_res_valid;
   logic [LABEL_W-1:0] r_res_label;
   logic [CNT_W-1:0]   r_res_count;
   logic               r_res_empty;

   logic [CNT_W-1:0]   w_cnt;
   logic               w_take;
   logic [CNT_W-1:0]   w_best_cnt_nx;
   logic [LABEL_W-1:0] w_best_lab_nx;

   function automatic logic [CNT_W-1:0] f_sat_nv(input logic [CNT_W-1:0] nv);
      return (nv > CNT_W'(K)) ? CNT_W'(K) : nv;
   endfunction

   // Votes for the rank under evaluation, counted only among the valid ranks.
   always_comb begin
      w_cnt = '0;
      for (int j = 0; j < K; j++) begin
         if ((CNT_W'(j) < r_nv) && (r_lab[j] == r_lab[r_idx]))
            w_cnt = w_cnt + CNT_W'(1);
      end
      w_take        = (CNT_W'(r_idx) < r_nv) && (w_cnt > r_best_cnt);
      w_best_cnt_nx = w_take ? w_cnt        : r_best_cnt;
      w_best_lab_nx = w_take ? r_lab[r_idx] : r_best_lab;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_sel       <= '0;
         r_nv        <= '0;
         for (int i = 0; i < K; i++) r_lab[i] <= '0;
         r_best_cnt  <= '0;
         r_best_lab  <= '0;
         r_busy      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_label <= '0;
         r_res_count <= '0;
         r_res_empty <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_nv    <= f_sat_nv(bus.nvalid);
                  r_idx   <= '0;
                  r_sel   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_lab[r_idx] <= bus.label_in;
               if (r_idx == LAST_IDX) begin
                  r_idx      <= '0;
                  r_sel      <= '0;
                  r_best_cnt <= '0;
                  r_best_lab <= '0;
                  r_state    <= S_VOTE;
               end else begin
                  r_idx <= r_idx + SEL_W'(1);
                  r_sel <= r_idx + SEL_W'(1);
               end
            end
            S_VOTE: begin
               r_best_cnt <= w_best_cnt_nx;
               r_best_lab <= w_best_lab_nx;
               if (r_idx == LAST_IDX) begin
                  r_idx       <= '0;
                  r_res_label <= w_best_lab_nx;
                  r_res_count <= w_best_cnt_nx;
                  r_res_empty <= (r_nv == '0);
                  r_res_valid <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_idx <= r_idx + SEL_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.sel          = r_sel;
   assign bus.busy         = r_busy;
   assign bus.result_valid = r_res_valid;
   assign bus.result_label = r_res_label;
   assign bus.result_count = r_res_count;
   assign bus.result_empty = r_res_empty;
endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote: a table-driven sorter model answers sel with a label,
// and each vote is tracked edge by edge against hand-computed results.
module tb_knn_vote;
   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   logic [7:0] lab_mem [4];

   knn_vote_if #(.LABEL_W(8), .SEL_W(2), .CNT_W(3)) bus ();

   knn_vote #(.K(4), .LABEL_W(8), .SEL_W(2), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.label_in = lab_mem[bus.sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive start for one edge (E0) and check the first FETCH cycle.
   task automatic start_vote(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [2:0] nv, input string tag);
      lab_mem[0] = a;
      lab_mem[1] = b;
      lab_mem[2] = c;
      lab_mem[3] = d;
      bus.nvalid = nv;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk($sformatf("%s_sel0", tag), 32'(bus.sel), 32'd0);
      chk($sformatf("%s_busy0", tag), 32'(bus.busy), 32'd1);
      chk($sformatf("%s_vld0", tag), 32'(bus.result_valid), 32'd0);
   endtask

   // Walk edges E0+1..E0+8; returns #1 after E0+8 (inside the result_valid cycle).
   task automatic track_vote(input string tag, input logic [7:0] el, input logic [2:0] ec,
                             input logic ee, input bit extra);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (k < 8) begin
            chk($sformatf("%s_sel%0d", tag, k), 32'(bus.sel), (k <= 3) ? 32'(k) : 32'd0);
            chk($sformatf("%s_busy%0d", tag, k), 32'(bus.busy), 32'd1);
            chk($sformatf("%s_vld%0d", tag, k), 32'(bus.result_valid), 32'd0);
         end else begin
            chk($sformatf("%s_vld", tag), 32'(bus.result_valid), 32'd1);
            chk($sformatf("%s_busy", tag), 32'(bus.busy), 32'd0);
            chk($sformatf("%s_label", tag), 32'(bus.result_label), 32'(el));
            chk($sformatf("%s_count", tag), 32'(bus.result_count), 32'(ec));
            chk($sformatf("%s_empty", tag), 32'(bus.result_empty), 32'(ee));
            chk($sformatf("%s_sel_end", tag), 32'(bus.sel), 32'd0);
         end
         if (extra && (k == 2 || k == 5)) bus.start = 1'b1;
      end
   endtask

   task automatic idle_check(input string tag, input int n, input logic [7:0] el);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s_idle_vld%0d", tag, k), 32'(bus.result_valid), 32'd0);
         chk($sformatf("%s_idle_busy%0d", tag, k), 32'(bus.busy), 32'd0);
         chk($sformatf("%s_hold%0d", tag, k), 32'(bus.result_label), 32'(el));
      end
   endtask

   initial begin
      n_assert   = 0;
      n_fail     = 0;
      rst        = 1'b0;
      bus.start  = 1'b0;
      bus.nvalid = '0;
      for (int i = 0; i < 4; i++) lab_mem[i] = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel",   32'(bus.sel),          32'd0);
      chk("rst_busy",  32'(bus.busy),         32'd0);
      chk("rst_vld",   32'(bus.result_valid), 32'd0);
      chk("rst_label", 32'(bus.result_label), 32'd0);
      chk("rst_count", 32'(bus.result_count), 32'd0);
      chk("rst_empty", 32'(bus.result_empty), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      start_vote(8'd3, 8'd3, 8'd7, 8'd1, 3'd4, "t1");
      track_vote("t1", 8'd3, 3'd2, 1'b0, 1'b0);
      idle_check("t1", 2, 8'd3);

      start_vote(8'd5, 8'd2, 8'd2, 8'd5, 3'd4, "t2");
      track_vote("t2", 8'd5, 3'd2, 1'b0, 1'b0);
      idle_check("t2", 2, 8'd5);

      start_vote(8'd9, 8'd4, 8'd4, 8'd4, 3'd2, "t3");
      track_vote("t3", 8'd9, 3'd1, 1'b0, 1'b0);
      idle_check("t3", 2, 8'd9);

      start_vote(8'd4, 8'd4, 8'd4, 8'd4, 3'd0, "t4a");
      track_vote("t4a", 8'd0, 3'd0, 1'b1, 1'b0);
      idle_check("t4a", 2, 8'd0);

      start_vote(8'd6, 8'd6, 8'd6, 8'd1, 3'd7, "t4b");
      track_vote("t4b", 8'd6, 3'd3, 1'b0, 1'b0);
      idle_check("t4b", 2, 8'd6);

      start_vote(8'd1, 8'd1, 8'd2, 8'd3, 3'd4, "t5");
      track_vote("t5", 8'd1, 3'd2, 1'b0, 1'b1);
      idle_check("t5", 10, 8'd1);

      start_vote(8'd7, 8'd7, 8'd7, 8'd7, 3'd4, "t5r");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("t5r_sel",   32'(bus.sel),          32'd0);
      chk("t5r_busy",  32'(bus.busy),         32'd0);
      chk("t5r_vld",   32'(bus.result_valid), 32'd0);
      chk("t5r_label", 32'(bus.result_label), 32'd0);
      chk("t5r_count", 32'(bus.result_count), 32'd0);
      chk("t5r_empty", 32'(bus.result_empty), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle_check("t5r", 10, 8'd0);

      start_vote(8'd2, 8'd9, 8'd9, 8'd2, 3'd4, "t5f");
      track_vote("t5f", 8'd2, 3'd2, 1'b0, 1'b0);
      idle_check("t5f", 2, 8'd2);

      start_vote(8'd1, 8'd2, 8'd3, 8'd4, 3'd4, "t6a");
      track_vote("t6a", 8'd1, 3'd1, 1'b0, 1'b0);
      start_vote(8'd8, 8'd8, 8'd2, 8'd8, 3'd4, "t6b");
      track_vote("t6b", 8'd8, 3'd3, 1'b0, 1'b0);
      idle_check("t6b", 3, 8'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
